// File: rtl/hit_judge.sv
// hit_judge
//   Per-frame hit arbitration between the two stick figures. Once per video
//   frame it samples both players' positions and action flags, detects landed
//   and blocked punches/kicks, keeps each player's health and declares the
//   winner.
//
// Ports:
//   Clk              system clock
//   Reset            synchronous, active-low reset
//   frame_clk        frame strobe, asynchronous to Clk
//   st               game running
//   BallX1, BallY1   player-1 position (10 bit)
//   BallX,  BallY    player-2 position (10 bit)
//   fight_1, kick_1, dodge_1   player-1 action flags
//   fight_2, kick_2, dodge_2   player-2 action flags
//   back1, back2     reaction code: 0 none, 1 block slide, 2 knockback
//   hp1, hp2         current health (7 bit)
//   p1win, p2win     win flags
module hit_judge #(
  parameter int HP_MAX       = 100,
  parameter int PUNCH_DMG    = 5,
  parameter int KICK_DMG     = 8,
  parameter int PUNCH_RANGE  = 60,
  parameter int KICK_RANGE   = 70,
  parameter int Y_RANGE      = 50,
  parameter int BLOCK_FRAMES = 8,
  parameter int KNOCK_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       st,
  input  logic [9:0] BallX1,
  input  logic [9:0] BallY1,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic       fight_1,
  input  logic       kick_1,
  input  logic       dodge_1,
  input  logic       fight_2,
  input  logic       kick_2,
  input  logic       dodge_2,
  output logic [1:0] back1,
  output logic [1:0] back2,
  output logic [6:0] hp1,
  output logic [6:0] hp2,
  output logic       p1win,
  output logic       p2win
);

  localparam logic [6:0] HP_INIT   = 7'(HP_MAX);
  localparam logic [6:0] P_DMG     = 7'(PUNCH_DMG);
  localparam logic [6:0] K_DMG     = 7'(KICK_DMG);
  localparam logic [9:0] P_RANGE   = 10'(PUNCH_RANGE);
  localparam logic [9:0] K_RANGE   = 10'(KICK_RANGE);
  localparam logic [9:0] YR        = 10'(Y_RANGE);
  localparam logic [4:0] BLK_INIT  = 5'(BLOCK_FRAMES);
  localparam logic [4:0] KNK_INIT  = 5'(KNOCK_FRAMES);

  typedef enum logic [1:0] {G_IDLE, G_PLAY, G_OVER} game_t;
  typedef enum logic [1:0] {R_NONE = 2'd0, R_BLOCK = 2'd1, R_KNOCK = 2'd2} react_t;

  typedef struct packed {
    react_t     react;
    logic [4:0] cnt;
    logic [6:0] hp;
  } def_t;

  game_t      game;
  react_t     react1, react2;
  logic [4:0] cnt1, cnt2;
  logic       sync1, sync2, sync3, tick;
  logic       prev_f1, prev_k1, prev_f2, prev_k2;

  logic [9:0] dx, dy;
  logic       rise_f1, rise_k1, rise_f2, rise_k2;
  logic       hit_on1, hit_on2;
  logic [6:0] dmg_on1, dmg_on2;
  def_t       cur1, cur2, nxt1, nxt2;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // One defender's reaction update. A defender already in knockback cannot be
  // hit again; otherwise a dodge turns the hit into a block with no damage.
  function automatic def_t resolve(input def_t cur, input logic hit,
                                   input logic dodge, input logic [6:0] dmg);
    def_t nxt;
    nxt = cur;
    if (hit && cur.react != R_KNOCK) begin
      if (dodge) begin
        nxt.react = R_BLOCK;
        nxt.cnt   = BLK_INIT;
      end else begin
        nxt.react = R_KNOCK;
        nxt.cnt   = KNK_INIT;
        nxt.hp    = (cur.hp > dmg) ? (cur.hp - dmg) : 7'd0;
      end
    end else if (cur.react != R_NONE) begin
      if (cur.cnt <= 5'd1) begin
        nxt.react = R_NONE;
        nxt.cnt   = 5'd0;
      end else begin
        nxt.cnt = cur.cnt - 5'd1;
      end
    end
    return nxt;
  endfunction

  assign back1 = react1;
  assign back2 = react2;

  // Hit detection: distances are symmetric, so one dx/dy pair serves both
  // attack directions. When kick and punch rise together only the kick counts,
  // even if the kick is out of range and the punch would have connected.
  always_comb begin
    dx      = abs_diff(BallX1, BallX);
    dy      = abs_diff(BallY1, BallY);
    rise_f1 = fight_1 & ~prev_f1;
    rise_k1 = kick_1  & ~prev_k1;
    rise_f2 = fight_2 & ~prev_f2;
    rise_k2 = kick_2  & ~prev_k2;
    hit_on2 = (dy <= YR) && (rise_k1 ? (dx <= K_RANGE) : (rise_f1 && dx <= P_RANGE));
    hit_on1 = (dy <= YR) && (rise_k2 ? (dx <= K_RANGE) : (rise_f2 && dx <= P_RANGE));
    dmg_on2 = rise_k1 ? K_DMG : P_DMG;
    dmg_on1 = rise_k2 ? K_DMG : P_DMG;
    cur1.react = react1;
    cur1.cnt   = cnt1;
    cur1.hp    = hp1;
    cur2.react = react2;
    cur2.cnt   = cnt2;
    cur2.hp    = hp2;
    nxt1 = resolve(cur1, hit_on1, dodge_1, dmg_on1);
    nxt2 = resolve(cur2, hit_on2, dodge_2, dmg_on2);
  end

  // Frame-strobe synchronizer, tick generation and the game FSM. Everything
  // except the synchronizer only moves on a tick, so outputs hold for a frame.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      tick    <= 1'b0;
      prev_f1 <= 1'b0;
      prev_k1 <= 1'b0;
      prev_f2 <= 1'b0;
      prev_k2 <= 1'b0;
      game    <= G_IDLE;
      react1  <= R_NONE;
      react2  <= R_NONE;
      cnt1    <= 5'd0;
      cnt2    <= 5'd0;
      hp1     <= HP_INIT;
      hp2     <= HP_INIT;
      p1win   <= 1'b0;
      p2win   <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
      if (tick) begin
        prev_f1 <= fight_1;
        prev_k1 <= kick_1;
        prev_f2 <= fight_2;
        prev_k2 <= kick_2;
        case (game)
          G_IDLE: begin
            hp1    <= HP_INIT;
            hp2    <= HP_INIT;
            react1 <= R_NONE;
            react2 <= R_NONE;
            cnt1   <= 5'd0;
            cnt2   <= 5'd0;
            p1win  <= 1'b0;
            p2win  <= 1'b0;
            if (st) game <= G_PLAY;
          end
          G_PLAY: begin
            if (!st) begin
              game   <= G_IDLE;
              hp1    <= HP_INIT;
              hp2    <= HP_INIT;
              react1 <= R_NONE;
              react2 <= R_NONE;
              cnt1   <= 5'd0;
              cnt2   <= 5'd0;
            end else begin
              react1 <= nxt1.react;
              cnt1   <= nxt1.cnt;
              hp1    <= nxt1.hp;
              react2 <= nxt2.react;
              cnt2   <= nxt2.cnt;
              hp2    <= nxt2.hp;
              // A knockout ends the round on this same tick; reactions are
              // cleared so the figures stand still on the result screen.
              if (nxt1.hp == 7'd0 || nxt2.hp == 7'd0) begin
                game   <= G_OVER;
                p1win  <= (nxt2.hp == 7'd0);
                p2win  <= (nxt1.hp == 7'd0);
                react1 <= R_NONE;
                react2 <= R_NONE;
                cnt1   <= 5'd0;
                cnt2   <= 5'd0;
              end
            end
          end
          G_OVER: begin
            if (!st) begin
              game  <= G_IDLE;
              hp1   <= HP_INIT;
              hp2   <= HP_INIT;
              p1win <= 1'b0;
              p2win <= 1'b0;
            end
          end
          default: game <= G_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge
//   Directed bench for hit_judge. Each frame step pushes the expected outputs
//   onto a queue before the frame strobe is driven, then pops and compares once
//   the frame has been processed.
module tb_hit_judge;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       st;
  logic [9:0] BallX1, BallY1, BallX, BallY;
  logic       fight_1, kick_1, dodge_1;
  logic       fight_2, kick_2, dodge_2;
  logic [1:0] back1, back2;
  logic [6:0] hp1, hp2;
  logic       p1win, p2win;

  typedef struct {
    logic [1:0] b1;
    logic [1:0] b2;
    logic [6:0] h1;
    logic [6:0] h2;
    logic       w1;
    logic       w2;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  hit_judge dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .st(st),
    .BallX1(BallX1), .BallY1(BallY1), .BallX(BallX), .BallY(BallY),
    .fight_1(fight_1), .kick_1(kick_1), .dodge_1(dodge_1),
    .fight_2(fight_2), .kick_2(kick_2), .dodge_2(dodge_2),
    .back1(back1), .back2(back2), .hp1(hp1), .hp2(hp2),
    .p1win(p1win), .p2win(p2win)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares every output against it.
  task automatic check_output();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      cmp("back1", {6'd0, back1}, {6'd0, x.b1});
      cmp("back2", {6'd0, back2}, {6'd0, x.b2});
      cmp("hp1",   {1'b0, hp1},   {1'b0, x.h1});
      cmp("hp2",   {1'b0, hp2},   {1'b0, x.h2});
      cmp("p1win", {7'd0, p1win}, {7'd0, x.w1});
      cmp("p2win", {7'd0, p2win}, {7'd0, x.w2});
    end
  endtask

  // One frame: strobe high for 4 clocks, low for 4, ending on a falling edge.
  task automatic apply_stimulus();
    sb.push_back(e);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic step();
    apply_stimulus();
    check_output();
  endtask

  task automatic reset_exp();
    e.b1 = 2'd0; e.b2 = 2'd0; e.h1 = 7'd100; e.h2 = 7'd100; e.w1 = 1'b0; e.w2 = 1'b0;
  endtask

  // A punch by either/both players followed by waiting out the knockback.
  task automatic hit_cycle(input bit p1, input bit p2);
    fight_1 = p1;
    fight_2 = p2;
    if (p1) begin e.h2 = e.h2 - 7'd5; e.b2 = 2'd2; end
    if (p2) begin e.h1 = e.h1 - 7'd5; e.b1 = 2'd2; end
    step();
    fight_1 = 1'b0;
    fight_2 = 1'b0;
    repeat (15) step();
    if (p1) e.b2 = 2'd0;
    if (p2) e.b1 = 2'd0;
    step();
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; st = 1'b0;
    BallX1 = 10'd300; BallY1 = 10'd300; BallX = 10'd350; BallY = 10'd300;
    fight_1 = 0; kick_1 = 0; dodge_1 = 0; fight_2 = 0; kick_2 = 0; dodge_2 = 0;
    reset_exp();

    // Reset values, then idle frames with st low change nothing.
    repeat (2) @(negedge Clk);
    sb.push_back(e);
    check_output();
    Reset = 1'b1;
    step();
    fight_1 = 1'b1;
    step();
    fight_1 = 1'b0;
    step();

    // Start the game, land a punch, hold the flag through the knockback.
    st = 1'b1;
    step();
    fight_1 = 1'b1;
    e.h2 = 7'd95; e.b2 = 2'd2;
    step();
    repeat (15) step();
    e.b2 = 2'd0;
    step();
    step();
    fight_1 = 1'b0;
    step();

    // Blocked kick, out-of-range kick, corner-of-range kick.
    dodge_2 = 1'b1; kick_1 = 1'b1; e.b2 = 2'd1;
    step();
    kick_1 = 1'b0;
    repeat (7) step();
    e.b2 = 2'd0;
    step();
    dodge_2 = 1'b0;
    BallX = 10'd371; kick_1 = 1'b1;
    step();
    kick_1 = 1'b0;
    step();
    BallX = 10'd370; BallY = 10'd350; kick_1 = 1'b1;
    e.h2 = 7'd87; e.b2 = 2'd2;
    step();
    kick_1 = 1'b0;
    repeat (15) step();
    e.b2 = 2'd0;
    step();

    // Mutual punch, then a re-punch during knockback is ignored.
    BallX = 10'd340; BallY = 10'd300;
    fight_1 = 1'b1; fight_2 = 1'b1;
    e.h1 = 7'd95; e.h2 = 7'd82; e.b1 = 2'd2; e.b2 = 2'd2;
    step();
    fight_1 = 1'b0; fight_2 = 1'b0;
    step();
    fight_1 = 1'b1;
    step();
    fight_1 = 1'b0;
    repeat (13) step();
    e.b1 = 2'd0; e.b2 = 2'd0;
    step();

    // Dropping st mid-game restores health; then grind player 2 down to KO.
    st = 1'b0; reset_exp();
    step();
    st = 1'b1;
    step();
    repeat (19) hit_cycle(1'b1, 1'b0);
    fight_1 = 1'b1; e.h2 = 7'd0; e.w1 = 1'b1;
    step();
    fight_1 = 1'b0; fight_2 = 1'b1;
    step();
    fight_2 = 1'b0;
    st = 1'b0; reset_exp();
    step();

    // Mutual knockout from 5/5 is a draw.
    st = 1'b1;
    step();
    repeat (19) hit_cycle(1'b1, 1'b1);
    fight_1 = 1'b1; fight_2 = 1'b1;
    e.h1 = 7'd0; e.h2 = 7'd0; e.w1 = 1'b1; e.w2 = 1'b1;
    step();
    fight_1 = 1'b0; fight_2 = 1'b0;
    step();

    // Reset in the middle of a knockback takes effect without a tick.
    st = 1'b0; reset_exp();
    step();
    st = 1'b1;
    step();
    fight_1 = 1'b1; e.h2 = 7'd95; e.b2 = 2'd2;
    step();
    fight_1 = 1'b0;
    repeat (7) step();
    Reset = 1'b0;
    @(negedge Clk);
    reset_exp();
    sb.push_back(e);
    check_output();
    Reset = 1'b1;
    st = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
